// File: rtl/corner_pkg.sv
// Shared types and constants for the corner-peak tile reducer and its result queue.
package corner_pkg;

  localparam int TILE_LOG2_DEF = 6;
  localparam int COORD_W       = 13;
  localparam int VAL_W         = 8;
  localparam int TILE_IDX_W    = 7;

  typedef struct packed {
    logic [VAL_W-1:0]      val;
    logic [COORD_W-1:0]    col;
    logic [COORD_W-1:0]    row;
    logic [TILE_IDX_W-1:0] tile_x;
    logic [TILE_IDX_W-1:0] tile_y;
    logic                  confident;
  } peak_result_t;

endpackage

// File: rtl/corner_peak_fifo.sv
// Synchronous FIFO of peak results; a push on a full queue is accepted when a pop
// happens in the same cycle.
module corner_peak_fifo
  import corner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  peak_result_t i_data,
  input  logic         i_pop,
  output peak_result_t o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  peak_result_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/corner_peak_tile.sv
// Reduces the corner-response stream to one peak per square tile and queues the results.
// Build option CORNER_PEAK_SUPPRESS_EN: drop tiles whose peak is below THRESH.
module corner_peak_tile
  import corner_pkg::*;
#(
  parameter int TILE_LOG2  = TILE_LOG2_DEF,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int THRESH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [VAL_W-1:0]      pix_in,
  input  logic [COORD_W-1:0]    col,
  input  logic [COORD_W-1:0]    row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VAL_W-1:0]      peak_val,
  output logic [COORD_W-1:0]    peak_col,
  output logic [COORD_W-1:0]    peak_row,
  output logic [TILE_IDX_W-1:0] tile_x,
  output logic [TILE_IDX_W-1:0] tile_y,
  output logic                  confident,
  output logic                  overflow
);

  localparam int T      = 1 << TILE_LOG2;
  localparam int NUM_TX = (IMG_W + T - 1) / T;
  localparam int TX_W   = (NUM_TX > 1) ? $clog2(NUM_TX) : 1;
  localparam logic [COORD_W-1:0] W_LIM    = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(IMG_H);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
  localparam logic [VAL_W-1:0]   THR      = VAL_W'(THRESH);

  // Stage 1: in-image pixel, registered.
  logic               r_s1_valid;
  logic [VAL_W-1:0]   r_s1_pix;
  logic [COORD_W-1:0] r_s1_col;
  logic [COORD_W-1:0] r_s1_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
    end else begin
      r_s1_valid <= in_valid && (col < W_LIM) && (row < H_LIM);
      r_s1_pix   <= pix_in;
      r_s1_col   <= col;
      r_s1_row   <= row;
    end
  end

  // Per tile-column running maximum.
  logic [VAL_W-1:0]   r_rec_val   [NUM_TX];
  logic [COORD_W-1:0] r_rec_col   [NUM_TX];
  logic [COORD_W-1:0] r_rec_row   [NUM_TX];
  logic               r_rec_valid [NUM_TX];

  logic [TX_W-1:0]    w_idx;
  logic               w_first;
  logic               w_close;
  logic               w_take;
  logic               w_rec_ok;
  logic               w_keep;
  logic               w_emit;
  peak_result_t       w_res;

  assign w_idx   = TX_W'(r_s1_col >> TILE_LOG2);
  assign w_first = (r_s1_col[TILE_LOG2-1:0] == '0) && (r_s1_row[TILE_LOG2-1:0] == '0);
  assign w_close = ((&r_s1_col[TILE_LOG2-1:0]) || (r_s1_col == LAST_COL)) &&
                   ((&r_s1_row[TILE_LOG2-1:0]) || (r_s1_row == LAST_ROW));
  // Strictly greater keeps the earlier pixel on ties.
  assign w_take   = w_first || (r_s1_pix > r_rec_val[w_idx]);
  assign w_rec_ok = w_first || r_rec_valid[w_idx];

  always_comb begin
    w_res.val       = w_take ? r_s1_pix : r_rec_val[w_idx];
    w_res.col       = w_take ? r_s1_col : r_rec_col[w_idx];
    w_res.row       = w_take ? r_s1_row : r_rec_row[w_idx];
    w_res.tile_x    = TILE_IDX_W'(r_s1_col >> TILE_LOG2);
    w_res.tile_y    = TILE_IDX_W'(r_s1_row >> TILE_LOG2);
    w_res.confident = (w_res.val >= THR);
  end

`ifdef CORNER_PEAK_SUPPRESS_EN
  assign w_keep = w_res.confident;
`else
  assign w_keep = 1'b1;
`endif

  assign w_emit = r_s1_valid && w_close && w_rec_ok && w_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TX; i++) begin
        r_rec_val[i]   <= '0;
        r_rec_col[i]   <= '0;
        r_rec_row[i]   <= '0;
        r_rec_valid[i] <= 1'b0;
      end
    end else if (r_s1_valid) begin
      r_rec_val[w_idx]   <= w_res.val;
      r_rec_col[w_idx]   <= w_res.col;
      r_rec_row[w_idx]   <= w_res.row;
      r_rec_valid[w_idx] <= w_rec_ok && !w_close;
    end
  end

  // Stage 2: closed tile waiting to enter the queue.
  logic         r_push;
  peak_result_t r_push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push      <= w_emit;
      r_push_data <= w_res;
    end
  end

  // Output handshake: a result transfers on a cycle with out_valid && out_ready;
  // while out_valid is high and out_ready low the head word is held unchanged.
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  peak_result_t w_head;
  logic         r_overflow;

  assign w_pop = out_valid && out_ready;

  corner_peak_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_overflow <= 1'b0;
    else if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
  end

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;
  assign peak_val  = w_head.val;
  assign peak_col  = w_head.col;
  assign peak_row  = w_head.row;
  assign tile_x    = w_head.tile_x;
  assign tile_y    = w_head.tile_y;
  assign confident = w_head.confident;

endmodule

// File: tb/tb_corner_peak_tile.sv
// Self-checking bench for corner_peak_tile on a reduced image geometry (8-pixel tiles,
// 44x28 image with partial edge tiles) so that whole frames stream quickly.
module tb_corner_peak_tile;

  localparam int TL     = 3;
  localparam int T      = 1 << TL;
  localparam int IMG_W  = 44;
  localparam int IMG_H  = 28;
  localparam int THRESH = 32;
  localparam int DEPTH  = 4;
  localparam int NTX    = (IMG_W + T - 1) / T;
  localparam int NBANDS = (IMG_H + T - 1) / T;
  localparam int RES_W  = 49;
`ifdef CORNER_PEAK_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  pix_in;
  logic [12:0] col;
  logic [12:0] row;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  peak_val;
  logic [12:0] peak_col;
  logic [12:0] peak_row;
  logic [6:0]  tile_x;
  logic [6:0]  tile_y;
  logic        confident;
  logic        overflow;

  corner_peak_tile #(
    .TILE_LOG2(TL), .IMG_W(IMG_W), .IMG_H(IMG_H), .THRESH(THRESH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pix_in(pix_in), .col(col), .row(row),
    .out_valid(out_valid), .out_ready(out_ready), .peak_val(peak_val),
    .peak_col(peak_col), .peak_row(peak_row), .tile_x(tile_x), .tile_y(tile_y),
    .confident(confident), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  logic [7:0]       frame [IMG_H][IMG_W];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               xfer_cnt = 0;
  int               ready_mode = 1;
  logic [RES_W-1:0] w_out;

  assign w_out = {peak_val, peak_col, peak_row, tile_x, tile_y, confident};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer-side monitor: transfers, ordering and hold-while-stalled.
  initial begin
    logic             hold_v;
    logic [RES_W-1:0] held;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) hold_v = 1'b0;
      else begin
        if (hold_v) check("stable", {out_valid, w_out}, {1'b1, held});
        hold_v = out_valid && !out_ready;
        held   = w_out;
        if (out_valid && out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) check("extra_result", out_valid, 1'b0);
          else check("result", w_out, exp_q.pop_front());
        end
      end
    end
  end

  // out_ready: 0, 1, or random with never more than two idle cycles in a row.
  initial begin
    int zeros;
    zeros = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 0) out_ready = 1'b0;
      else if (ready_mode == 1) out_ready = 1'b1;
      else begin
        out_ready = (zeros >= 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
        zeros = out_ready ? 0 : zeros + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Each tile's result is the raster-first maximum over its pixels; results leave
  // in close order (band by band, left to right).
  task automatic model_push(input int nbands, input int skip_band, input int keep,
                            output int n);
    int best, bc, br;
    n = 0;
    for (int ty = 0; ty < nbands; ty++) begin
      if (ty == skip_band) continue;
      for (int tx = 0; tx < NTX; tx++) begin
        best = -1; bc = 0; br = 0;
        for (int y = ty * T; y < (ty + 1) * T && y < IMG_H; y++)
          for (int x = tx * T; x < (tx + 1) * T && x < IMG_W; x++)
            if (int'(frame[y][x]) > best) begin
              best = int'(frame[y][x]); bc = x; br = y;
            end
        if (SUPPRESS && best < THRESH) continue;
        if (n < keep) begin
          exp_q.push_back({8'(best), 13'(bc), 13'(br), 7'(tx), 7'(ty), (best >= THRESH)});
          n++;
        end
      end
    end
  endtask

  task automatic fill(input int lo, input int hi);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        frame[y][x] = 8'($urandom_range(lo, hi));
  endtask

  // ---------------- drivers ----------------
  task automatic send_pix(input logic v, input logic [7:0] p, input int c, input int r);
    in_valid = v;
    pix_in   = p;
    col      = 13'(c);
    row      = 13'(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_pix(1'b0, 8'h00, 0, 0);
  endtask

  // Raster stream with optional bubbles / out-of-image junk and an optional reset window.
  task automatic stream(input int nrows, input int bubble_pct, input int rst_row);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (r == rst_row && c == 0) rst = 1'b1;
        if (r == rst_row + 2 && c == 0) rst = 1'b0;
        while ($urandom_range(0, 99) < bubble_pct) begin
          case ($urandom_range(0, 2))
            0:       send_pix(1'b0, 8'hff, $urandom_range(0, IMG_W - 1), $urandom_range(0, IMG_H - 1));
            1:       send_pix(1'b1, 8'hff, IMG_W + $urandom_range(0, 40), r);
            default: send_pix(1'b1, 8'hff, c, IMG_H + $urandom_range(0, 40));
          endcase
        end
        send_pix(1'b1, frame[r][c], c, r);
        if (r == rst_row && c == 0) begin
          check("rst_out_valid", out_valid, 1'b0);
          check("rst_overflow", overflow, 1'b0);
        end
      end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic run_frame(input string tag, input int bubble_pct, input int rst_row);
    int n, x0;
    x0 = xfer_cnt;
    model_push(NBANDS, (rst_row >= 0) ? rst_row / T : -1, 1000, n);
    stream(IMG_H, bubble_pct, rst_row);
    idle(4);
    drain({tag, "_drain"});
    check({tag, "_count"}, xfer_cnt - x0, n);
  endtask

  // One tile band with no bubbles and a stalled consumer. With pop_at_push the
  // consumer wakes exactly on the edge where the fifth result enters the full queue.
  task automatic tight_band(input string tag, input bit pop_at_push);
    int n, x0;
    x0 = xfer_cnt;
    fill(40, 255);
    model_push(1, -1, pop_at_push ? 1000 : DEPTH, n);
    ready_mode = 0;
    for (int r = 0; r < T; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (pop_at_push && r == T - 1 && c == 5 * T + 1) ready_mode = 1;
        send_pix(1'b1, frame[r][c], c, r);
        if (r == T - 1 && c == T)     check({tag, "_lat_pre"}, out_valid, 1'b0);
        if (r == T - 1 && c == T + 1) check({tag, "_lat_post"}, out_valid, 1'b1);
      end
    idle(4);
    check({tag, "_overflow"}, overflow, !pop_at_push);
    ready_mode = 1;
    drain({tag, "_drain"});
    check({tag, "_count"}, xfer_cnt - x0, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    pix_in = '0;
    col = '0;
    row = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", w_out, '0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    idle(2);

    fill(0, 0);
    frame[5][3] = 8'd200;
    run_frame("single", 10, -1);

    fill(0, 0);
    frame[1][T + 1] = 8'd90;
    frame[3][T + 5] = 8'd90;
    run_frame("tie", 20, -1);

    fill(10, 10);
    run_frame("uniform", 10, -1);

    ready_mode = 2;
    fill(0, 255);
    run_frame("rand_a", 30, -1);
    fill(0, 255);
    run_frame("rand_b", 0, -1);
    fill(0, 255);
    run_frame("mid_reset", 25, 11);
    ready_mode = 1;
    idle(2);

    tight_band("full_pop", 1'b1);
    tight_band("drop", 1'b0);
    check("overflow_sticky", overflow, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
